// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use hazard unit for the pipelined MIPS core.
// EX/MEM forwarding wins over MEM/WB; load-use stalls last MEM_LAT cycles.
module hazard_forward_unit #(
  parameter int AW           = 5,
  parameter int N_SRC        = 2,
  parameter int MEM_LAT      = 1,
  parameter int ZERO_REG_FWD = 0,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC*AW-1:0]   id_ex_src,
  input  logic [AW-1:0]         ex_mem_rd,
  input  logic                  ex_mem_regwrite,
  input  logic [AW-1:0]         mem_wb_rd,
  input  logic                  mem_wb_regwrite,
  input  logic [N_SRC*AW-1:0]   if_id_src,
  input  logic [N_SRC-1:0]      if_id_src_used,
  input  logic [AW-1:0]         id_ex_rd,
  input  logic                  id_ex_memread,
  input  logic                  flush,
  input  logic                  stat_clr,
  output logic [2*N_SRC-1:0]    forward_sel,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state, next_state;
  logic [3:0] rem, next_rem;
  logic       mem_ok, wb_ok, hazard, src_hit, stall_int;

  // Writes to register 0 are discarded when it is hard-wired to zero.
  assign mem_ok = ex_mem_regwrite & ~((ZERO_REG_FWD != 0) && (ex_mem_rd == '0));
  assign wb_ok  = mem_wb_regwrite & ~((ZERO_REG_FWD != 0) && (mem_wb_rd == '0));

  always_comb begin
    forward_sel = '0;
    src_hit     = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (mem_ok && (ex_mem_rd == id_ex_src[i*AW +: AW]))
        forward_sel[2*i +: 2] = 2'b01;
      else if (wb_ok && (mem_wb_rd == id_ex_src[i*AW +: AW]))
        forward_sel[2*i +: 2] = 2'b10;
      if (if_id_src_used[i] && (if_id_src[i*AW +: AW] == id_ex_rd))
        src_hit = 1'b1;
    end
    hazard = id_ex_memread & src_hit &
             ~((ZERO_REG_FWD != 0) && (id_ex_rd == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem   <= 4'd0;
    end else begin
      state <= next_state;
      rem   <= next_rem;
    end
  end

  // The first stall cycle is spent in IDLE, so WAIT covers the remaining MEM_LAT-1.
  always_comb begin
    next_state = state;
    next_rem   = rem;
    stall_int  = 1'b0;
    case (state)
      IDLE: begin
        stall_int = hazard & ~flush;
        if (stall_int && (MEM_LAT > 1)) begin
          next_state = WAIT;
          next_rem   = 4'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        stall_int = ~flush;
        if (flush || (rem == 4'd1)) begin
          next_state = IDLE;
          next_rem   = 4'd0;
        end else begin
          next_rem = rem - 4'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_rem   = 4'd0;
      end
    endcase
  end

  assign stall  = stall_int & ~rst;
  assign bubble = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stat_clr)
      stall_count <= '0;
    else if (stall && !(&stall_count))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a MEM_LAT=3/CNT_W=4 instance and a
// MEM_LAT=1/ZERO_REG_FWD=1 instance share one set of stimulus inputs.
module tb_hazard_forward_unit;

  logic        clk;
  logic        rst;
  logic [9:0]  id_ex_src;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwrite;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite;
  logic [9:0]  if_id_src;
  logic [1:0]  if_id_src_used;
  logic [4:0]  id_ex_rd;
  logic        id_ex_memread;
  logic        flush;
  logic        stat_clr;

  logic [3:0]  sel_a, sel_b;
  logic        stall_a, stall_b, bubble_a, bubble_b;
  logic [3:0]  count_a;
  logic [15:0] count_b;

  int checks;
  int failures;

  hazard_forward_unit #(.AW(5), .N_SRC(2), .MEM_LAT(3), .ZERO_REG_FWD(0), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_ex_src(id_ex_src), .ex_mem_rd(ex_mem_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .if_id_src(if_id_src), .if_id_src_used(if_id_src_used), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .flush(flush), .stat_clr(stat_clr),
    .forward_sel(sel_a), .stall(stall_a), .bubble(bubble_a), .stall_count(count_a)
  );

  hazard_forward_unit #(.AW(5), .N_SRC(2), .MEM_LAT(1), .ZERO_REG_FWD(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_ex_src(id_ex_src), .ex_mem_rd(ex_mem_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .if_id_src(if_id_src), .if_id_src_used(if_id_src_used), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .flush(flush), .stat_clr(stat_clr),
    .forward_sel(sel_b), .stall(stall_b), .bubble(bubble_b), .stall_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] src;
    logic [4:0] mrd;
    logic       mwr;
    logic [4:0] wrd;
    logic       wwr;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    id_ex_src       = v.src;
    ex_mem_rd       = v.mrd;
    ex_mem_regwrite = v.mwr;
    mem_wb_rd       = v.wrd;
    mem_wb_regwrite = v.wwr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setHazard(input logic on, input logic [1:0] used);
    id_ex_memread  = on;
    id_ex_rd       = 5'd9;
    if_id_src      = {5'd4, 5'd9};
    if_id_src_used = used;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{{5'd3,  5'd8},  5'd8,  1'b1, 5'd8,  1'b1, 4'b0001, 4'b0001};
    vecs[1] = '{{5'd3,  5'd8},  5'd8,  1'b0, 5'd8,  1'b1, 4'b0010, 4'b0010};
    vecs[2] = '{{5'd3,  5'd8},  5'd8,  1'b0, 5'd8,  1'b0, 4'b0000, 4'b0000};
    vecs[3] = '{{5'd0,  5'd5},  5'd0,  1'b1, 5'd5,  1'b1, 4'b0110, 4'b0010};
    vecs[4] = '{{5'd7,  5'd7},  5'd7,  1'b1, 5'd7,  1'b0, 4'b0101, 4'b0101};
    vecs[5] = '{{5'd6,  5'd4},  5'd6,  1'b1, 5'd4,  1'b1, 4'b0110, 4'b0110};
    vecs[6] = '{{5'd0,  5'd0},  5'd3,  1'b1, 5'd0,  1'b1, 4'b1010, 4'b0000};
    vecs[7] = '{{5'd30, 5'd31}, 5'd31, 1'b1, 5'd30, 1'b1, 4'b1001, 4'b1001};

    rst = 1'b1;
    id_ex_src = '0; ex_mem_rd = '0; ex_mem_regwrite = 1'b0;
    mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
    if_id_src = '0; if_id_src_used = '0; id_ex_rd = '0; id_ex_memread = 1'b0;
    flush = 1'b0; stat_clr = 1'b0;
    #2;
    checkOutput("reset_sel_a", 32'(sel_a), 32'h0);
    checkOutput("reset_stall_a", 32'(stall_a), 32'h0);
    checkOutput("reset_count_a", 32'(count_a), 32'h0);
    checkOutput("reset_count_b", 32'(count_b), 32'h0);
    setHazard(1'b1, 2'b01);
    checkOutput("reset_hazard_stall_a", 32'(stall_a), 32'h0);
    checkOutput("reset_hazard_stall_b", 32'(stall_b), 32'h0);
    setHazard(1'b0, 2'b00);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("fwd_a_%0d", i), 32'(sel_a), 32'(vecs[i].exp_a));
      checkOutput($sformatf("fwd_b_%0d", i), 32'(sel_b), 32'(vecs[i].exp_b));
    end
    ex_mem_regwrite = 1'b0;
    mem_wb_regwrite = 1'b0;
    step();

    // Load-use with MEM_LAT=3: exactly three stall cycles.
    setHazard(1'b1, 2'b01);
    checkOutput("lu_c1_stall_a", 32'(stall_a), 32'h1);
    checkOutput("lu_c1_bubble_a", 32'(bubble_a), 32'h1);
    checkOutput("lu_c1_stall_b", 32'(stall_b), 32'h1);
    step();
    setHazard(1'b0, 2'b00);
    checkOutput("lu_c2_stall_a", 32'(stall_a), 32'h1);
    checkOutput("lu_c2_stall_b", 32'(stall_b), 32'h0);
    step();
    checkOutput("lu_c3_stall_a", 32'(stall_a), 32'h1);
    checkOutput("lu_c3_bubble_a", 32'(bubble_a), 32'h1);
    step();
    checkOutput("lu_c4_stall_a", 32'(stall_a), 32'h0);
    checkOutput("lu_count_a", 32'(count_a), 32'h3);
    checkOutput("lu_count_b", 32'(count_b), 32'h1);

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    checkOutput("clr_count_a", 32'(count_a), 32'h0);

    // Operand matches but is not read: no stall.
    setHazard(1'b1, 2'b10);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("unused_stall_a_%0d", i), 32'(stall_a), 32'h0);
      step();
    end
    setHazard(1'b0, 2'b00);
    checkOutput("unused_count_a", 32'(count_a), 32'h0);

    // Flush in the second stall cycle.
    setHazard(1'b1, 2'b01);
    checkOutput("abort_c1_stall_a", 32'(stall_a), 32'h1);
    step();
    setHazard(1'b0, 2'b00);
    flush = 1'b1;
    #1;
    checkOutput("abort_c2_stall_a", 32'(stall_a), 32'h0);
    checkOutput("abort_c2_bubble_a", 32'(bubble_a), 32'h0);
    step();
    flush = 1'b0;
    #1;
    checkOutput("abort_c3_stall_a", 32'(stall_a), 32'h0);
    step();
    checkOutput("abort_c4_stall_a", 32'(stall_a), 32'h0);
    checkOutput("abort_count_a", 32'(count_a), 32'h1);

    // A new hazard is seen in the first IDLE cycle after WAIT.
    setHazard(1'b1, 2'b01);
    step();
    setHazard(1'b0, 2'b00);
    step();
    step();
    setHazard(1'b1, 2'b01);
    checkOutput("b2b_stall_a", 32'(stall_a), 32'h1);
    step();
    setHazard(1'b0, 2'b00);
    step();
    step();
    checkOutput("b2b_idle_stall_a", 32'(stall_a), 32'h0);

    // Continuous hazard saturates the 4-bit counter.
    setHazard(1'b1, 2'b01);
    for (int i = 0; i < 20; i++) step();
    checkOutput("sat_stall_a", 32'(stall_a), 32'h1);
    checkOutput("sat_count_a", 32'(count_a), 32'hF);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    checkOutput("clr_while_stall_count_a", 32'(count_a), 32'h0);
    setHazard(1'b0, 2'b00);
    step();
    step();
    step();
    checkOutput("pre_rst_stall_a", 32'(stall_a), 32'h0);

    // Reset asserted in the middle of WAIT.
    setHazard(1'b1, 2'b01);
    step();
    setHazard(1'b0, 2'b00);
    checkOutput("midwait_stall_a", 32'(stall_a), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("midwait_rst_stall_a", 32'(stall_a), 32'h0);
    checkOutput("midwait_rst_count_a", 32'(count_a), 32'h0);
    step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_stall_a", 32'(stall_a), 32'h0);
    step();
    checkOutput("post_rst_stall2_a", 32'(stall_a), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
